// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Sample FIFO between the DMA AXI-stream and the JESD204 TPL DAC read port, with prime and underflow.
// Define AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN to replay the last popped beat on underflow.
module ad_ip_jesd204_tpl_dac_fifo #(
   parameter int unsigned DATA_WIDTH   = 128,
   parameter int unsigned NUM_CHANNELS = 2,
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter int unsigned PRIME_LEVEL  = 8
) (
   input  logic                    link_clk,
   input  logic                    link_resetn,
   input  logic                    s_axis_valid,
   output logic                    s_axis_ready,
   input  logic [DATA_WIDTH-1:0]   s_axis_data,
   input  logic [NUM_CHANNELS-1:0] enable,
   input  logic [NUM_CHANNELS-1:0] dac_valid,
   output logic [DATA_WIDTH-1:0]   dac_ddata,
   output logic                    dac_dunf,
   output logic [DEPTH_LOG2:0]     fifo_level
);

   localparam int unsigned         Depth      = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PrimeLevel = PRIME_LEVEL[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] FullDiff   = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] PtrOne     = {{DEPTH_LOG2{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] mem [Depth];
   logic [DEPTH_LOG2:0]   wr_ptr_q;
   logic [DEPTH_LOG2:0]   wr_ptr_d;
   logic [DEPTH_LOG2:0]   rd_ptr_q;
   logic                  ready_en_q;
   logic                  full;
   logic                  empty;
   logic                  wr_en;
   logic                  rd_req;
   logic                  playback_on;
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN
   logic [DATA_WIDTH-1:0] last_q;
`endif

   always_comb begin
      full         = (wr_ptr_q ^ rd_ptr_q) == FullDiff;
      empty        = wr_ptr_q == rd_ptr_q;
      s_axis_ready = ready_en_q & ~full;
      wr_en        = s_axis_valid & s_axis_ready;
      wr_ptr_d     = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
      fifo_level   = wr_ptr_q - rd_ptr_q;
      rd_req       = |dac_valid;
      playback_on  = |enable;
   end

   always_ff @(posedge link_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_axis_data;
      end
   end

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ready_en_q <= 1'b0;
         dac_ddata  <= '0;
         dac_dunf   <= 1'b0;
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN
         last_q     <= '0;
`endif
      end else begin
         ready_en_q <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         dac_dunf   <= 1'b0;
         if (rd_req && state_q != StRun) begin
            dac_ddata <= '0;
         end
         case (state_q)
            StIdle: begin
               // Flush against the post-write pointer so same-cycle writes are dropped too.
               rd_ptr_q <= wr_ptr_d;
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN
               last_q   <= '0;
`endif
               if (playback_on) begin
                  state_q <= StPrime;
               end
            end
            StPrime: begin
               if (fifo_level >= PrimeLevel) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (rd_req) begin
                  if (!empty) begin
                     dac_ddata <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
                     rd_ptr_q  <= rd_ptr_q + PtrOne;
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN
                     last_q    <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
`endif
                  end else begin
                     dac_dunf  <= 1'b1;
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN
                     dac_ddata <= last_q;
`else
                     dac_ddata <= '0;
`endif
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
         if (!playback_on) begin
            state_q <= StIdle;
         end
      end
   end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Directed self-checking bench for ad_ip_jesd204_tpl_dac_fifo (DEPTH_LOG2=4, PRIME_LEVEL=8).
module tb_ad_ip_jesd204_tpl_dac_fifo;

   localparam int DW = 128;

   logic          link_clk = 1'b0;
   logic          link_resetn = 1'b0;
   logic          s_axis_valid = 1'b0;
   logic          s_axis_ready;
   logic [DW-1:0] s_axis_data = '0;
   logic [1:0]    enable = 2'b00;
   logic [1:0]    dac_valid = 2'b00;
   logic [DW-1:0] dac_ddata;
   logic          dac_dunf;
   logic [4:0]    fifo_level;

   int total = 0;
   int bad = 0;

   ad_ip_jesd204_tpl_dac_fifo #(
      .DATA_WIDTH(DW),
      .NUM_CHANNELS(2),
      .DEPTH_LOG2(4),
      .PRIME_LEVEL(8)
   ) dut (
      .link_clk(link_clk),
      .link_resetn(link_resetn),
      .s_axis_valid(s_axis_valid),
      .s_axis_ready(s_axis_ready),
      .s_axis_data(s_axis_data),
      .enable(enable),
      .dac_valid(dac_valid),
      .dac_ddata(dac_ddata),
      .dac_dunf(dac_dunf),
      .fifo_level(fifo_level)
   );

   always #5 link_clk = ~link_clk;

   task automatic tick();
      @(posedge link_clk);
      #1;
   endtask

   task automatic test_reset();
      link_resetn = 1'b0;
      tick();
      tick();
      total++; if (s_axis_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", s_axis_ready); end
      total++; if (dac_ddata !== '0) begin bad++; $display("FAIL reset_ddata got=%0h want=0", dac_ddata); end
      total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL reset_dunf got=%0b want=0", dac_dunf); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
      link_resetn = 1'b1;
      tick();
      total++; if (s_axis_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b want=1", s_axis_ready); end
   endtask

   task automatic test_idle_flush();
      enable = 2'b00;
      dac_valid = 2'b11;
      s_axis_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_axis_data = DW'(100 + i);
         tick();
         total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL idle_level got=%0d want=0", fifo_level); end
         total++; if (s_axis_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0b want=1", s_axis_ready); end
         total++; if (dac_ddata !== '0) begin bad++; $display("FAIL idle_ddata got=%0h want=0", dac_ddata); end
         total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL idle_dunf got=%0b want=0", dac_dunf); end
      end
      s_axis_valid = 1'b0;
      dac_valid = 2'b00;
   endtask

   task automatic test_prime_run();
      enable = 2'b11;
      tick();
      dac_valid = 2'b11;
      for (int k = 1; k <= 8; k++) begin
         s_axis_valid = 1'b1;
         s_axis_data = DW'(k);
         tick();
         total++; if (dac_ddata !== '0) begin bad++; $display("FAIL prime_ddata got=%0h want=0", dac_ddata); end
         total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL prime_dunf got=%0b want=0", dac_dunf); end
         total++; if (fifo_level !== 5'(k)) begin bad++; $display("FAIL prime_level got=%0d want=%0d", fifo_level, k); end
      end
      s_axis_valid = 1'b0;
      tick();
      total++; if (dac_ddata !== '0) begin bad++; $display("FAIL prime_last_ddata got=%0h want=0", dac_ddata); end
      total++; if (fifo_level !== 5'd8) begin bad++; $display("FAIL prime_last_level got=%0d want=8", fifo_level); end
      for (int k = 1; k <= 8; k++) begin
         tick();
         total++; if (dac_ddata !== DW'(k)) begin bad++; $display("FAIL run_ddata got=%0h want=%0h", dac_ddata, k); end
         total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL run_dunf got=%0b want=0", dac_dunf); end
         total++; if (fifo_level !== 5'(8 - k)) begin bad++; $display("FAIL run_level got=%0d want=%0d", fifo_level, 8 - k); end
      end
   endtask

   task automatic test_underflow();
      logic [DW-1:0] exp_unf;
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN
      exp_unf = DW'(8);
`else
      exp_unf = '0;
`endif
      // Write into an empty FIFO in the same cycle as a read: the read still starves.
      s_axis_valid = 1'b1;
      s_axis_data = DW'(9);
      dac_valid = 2'b11;
      tick();
      total++; if (dac_dunf !== 1'b1) begin bad++; $display("FAIL unf_dunf got=%0b want=1", dac_dunf); end
      total++; if (dac_ddata !== exp_unf) begin bad++; $display("FAIL unf_ddata got=%0h want=%0h", dac_ddata, exp_unf); end
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL unf_level got=%0d want=1", fifo_level); end
      s_axis_valid = 1'b0;
      tick();
      total++; if (dac_ddata !== DW'(9)) begin bad++; $display("FAIL unf_next_ddata got=%0h want=9", dac_ddata); end
      total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL unf_next_dunf got=%0b want=0", dac_dunf); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL unf_next_level got=%0d want=0", fifo_level); end
      dac_valid = 2'b00;
      tick();
      total++; if (dac_ddata !== DW'(9)) begin bad++; $display("FAIL hold_ddata got=%0h want=9", dac_ddata); end
      total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL hold_dunf got=%0b want=0", dac_dunf); end
   endtask

   task automatic test_full();
      dac_valid = 2'b00;
      s_axis_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_axis_data = DW'(200 + i);
         tick();
      end
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d want=16", fifo_level); end
      total++; if (s_axis_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", s_axis_ready); end
      s_axis_data = DW'(999);
      tick();
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_hold_level got=%0d want=16", fifo_level); end
      s_axis_valid = 1'b0;
      dac_valid = 2'b11;
      tick();
      total++; if (dac_ddata !== DW'(200)) begin bad++; $display("FAIL full_pop_ddata got=%0h want=%0h", dac_ddata, 200); end
      total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL full_pop_level got=%0d want=15", fifo_level); end
      total++; if (s_axis_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%0b want=1", s_axis_ready); end
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++; if (dac_ddata !== DW'(200 + i)) begin bad++; $display("FAIL drain_ddata got=%0h want=%0h", dac_ddata, 200 + i); end
         total++; if (fifo_level !== 5'(15 - i)) begin bad++; $display("FAIL drain_level got=%0d want=%0d", fifo_level, 15 - i); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] q[$];
      logic [DW-1:0] exp;
      for (int i = 211; i <= 215; i++) q.push_back(DW'(i));
      s_axis_valid = 1'b1;
      dac_valid = 2'b11;
      for (int i = 0; i < 40; i++) begin
         s_axis_data = DW'(300 + i);
         tick();
         exp = q.pop_front();
         q.push_back(DW'(300 + i));
         total++; if (dac_ddata !== exp) begin bad++; $display("FAIL b2b_ddata got=%0h want=%0h", dac_ddata, exp); end
         total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL b2b_level got=%0d want=5", fifo_level); end
         total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL b2b_dunf got=%0b want=0", dac_dunf); end
      end
      s_axis_valid = 1'b0;
      dac_valid = 2'b00;
   endtask

   task automatic test_reset_mid();
      s_axis_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_axis_data = DW'(400 + i);
         tick();
      end
      s_axis_valid = 1'b0;
      total++; if (fifo_level !== 5'd10) begin bad++; $display("FAIL mid_pre_level got=%0d want=10", fifo_level); end
      #2;
      link_resetn = 1'b0;
      #1;
      total++; if (dac_ddata !== '0) begin bad++; $display("FAIL mid_ddata got=%0h want=0", dac_ddata); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
      total++; if (s_axis_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%0b want=0", s_axis_ready); end
      total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL mid_dunf got=%0b want=0", dac_dunf); end
      tick();
      link_resetn = 1'b1;
      tick();
      s_axis_valid = 1'b1;
      s_axis_data = DW'(50);
      dac_valid = 2'b11;
      tick();
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL reprime_level got=%0d want=1", fifo_level); end
      s_axis_valid = 1'b0;
      tick();
      total++; if (dac_ddata !== '0) begin bad++; $display("FAIL reprime_ddata got=%0h want=0", dac_ddata); end
      total++; if (dac_dunf !== 1'b0) begin bad++; $display("FAIL reprime_dunf got=%0b want=0", dac_dunf); end
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL reprime_hold_level got=%0d want=1", fifo_level); end
   endtask

   task automatic test_disable();
      enable = 2'b00;
      dac_valid = 2'b00;
      tick();
      tick();
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL disable_level got=%0d want=0", fifo_level); end
   endtask

   initial begin
      test_reset();
      test_idle_flush();
      test_prime_run();
      test_underflow();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_disable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_fifo.md
# ad_ip_jesd204_tpl_dac_fifo

Sample buffer directly upstream of the JESD204 TPL DAC core. It accepts beats from the DMA over an AXI-stream slave and returns them on the TPL's DMA-side read interface (`dac_valid` in, `dac_ddata`/`dac_dunf` out). It absorbs DMA jitter, holds off playback until a prime level is reached, and flags underflow. Single clock domain: `link_clk`.

## Interface
Parameters:
- `DATA_WIDTH`, 128, beat width; equals NUM_LANES*8*OCTETS_PER_BEAT of the TPL.
- `NUM_CHANNELS`, 2, width of `dac_valid` and `enable`.
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 beats (legal range 2..10).
- `PRIME_LEVEL`, 8, fill level required before leaving PRIME (1..2^DEPTH_LOG2).

Ports:
- `link_clk`  in  1  sole clock; all logic on its rising edge.
- `link_resetn`  in  1  reset, asynchronous assert, active-low.
- `s_axis_valid`  in  1  DMA beat valid.
- `s_axis_ready`  out  1  FIFO can accept a beat.
- `s_axis_data`  in  DATA_WIDTH  DMA beat.
- `enable`  in  NUM_CHANNELS  channel enables from the TPL; all-zero = playback off.
- `dac_valid`  in  NUM_CHANNELS  read strobes from the TPL; read request = OR of bits.
- `dac_ddata`  out  DATA_WIDTH  sample beat to the TPL.
- `dac_dunf`  out  1  underflow flag, one pulse per starved read.
- `fifo_level`  out  DEPTH_LOG2+1  current occupancy (0..2^DEPTH_LOG2).

## Operation
- Storage: 2^DEPTH_LOG2 x DATA_WIDTH RAM, binary write/read pointers with DEPTH_LOG2+1 bits; full when pointers differ only in MSB, empty when equal.
- Write: beat stored when `s_axis_valid && s_axis_ready`; `s_axis_ready` = !full, independent of state.
- Read request `rd_req` = |dac_valid.
- FSM, states IDLE, PRIME, RUN:
  - IDLE: entered on reset and whenever `enable` == 0 (from any state). FIFO is flushed (read pointer set to write pointer) every IDLE cycle; writes are still accepted but discarded by the flush. Go to PRIME when `enable` != 0.
  - PRIME: reads not popped; `rd_req` returns zero data, no `dac_dunf`. Go to RUN when `fifo_level` >= PRIME_LEVEL.
  - RUN: `rd_req` with FIFO non-empty pops one beat. `rd_req` with FIFO empty is an underflow: no pop, underflow data returned, `dac_dunf` pulses; state stays RUN (no re-prime).
- Simultaneous write and read in the same cycle: both happen; `fifo_level` unchanged. Write into an empty FIFO is not readable in that same cycle (read sees empty -> underflow).
- Write while full: not possible (ready low); beat held by DMA.
- Pointer wrap: natural modulo 2^(DEPTH_LOG2+1); no special casing.

## Timing
- Reset values: `s_axis_ready` 0 during reset, 1 from the first cycle after release; `dac_ddata` 0; `dac_dunf` 0; `fifo_level` 0; state IDLE.
- Read latency: `dac_ddata` and `dac_dunf` registered, valid exactly 1 cycle after the `rd_req` cycle; they hold value when `rd_req` is low (`dac_dunf` clears to 0 next cycle).
- Write-to-level latency: `fifo_level` updates the cycle after the handshake.
- PRIME->RUN transition: the cycle after `fifo_level` reaches PRIME_LEVEL; first pop possible on that RUN cycle.
- Reset asserted mid-operation: pointers, level, outputs and state clear immediately; stored data is not preserved.
- Throughput: one write and one read per cycle sustained.

## Configuration
- `AD_IP_JESD204_TPL_DAC_FIFO_REPEAT_EN`: when defined, underflow reads in RUN return the last successfully popped beat (held in `dac_ddata`, 0 if none since IDLE); `dac_dunf` still pulses. When undefined, underflow reads return all-zero data. PRIME/IDLE reads return zero in both builds.

## Test plan
- Reset release, `enable`=0, DMA pushes 3 beats -> `s_axis_ready`=1, level stays 0 (flush), `dac_ddata`=0, no `dac_dunf`.
- `enable`=2'b11, DEPTH_LOG2=4, PRIME_LEVEL=8, push beats 1..8 while `dac_valid`=11 every cycle -> zero data, no dunf until level 8; next cycle RUN; `dac_ddata` = 1,2,3... one cycle after each strobe.
- Push 16 beats without reads -> level 16, `s_axis_ready`=0; one read -> ready=1 next cycle, level 15.
- RUN with FIFO empty, `dac_valid` pulse -> `dac_dunf`=1 for one cycle 1 cycle later, `dac_ddata`=0 (or last beat with REPEAT_EN); next push then read returns that beat, dunf=0.
- Simultaneous push/pop for 40 cycles at level 5 -> level constant 5, data in order across pointer wrap.
- `link_resetn` pulsed low while RUN at level 10 -> all outputs 0 asynchronously, level 0, state IDLE; re-prime required.
